wb_stage: RTL and testbench

Writeback stage of the five-stage MIPS core, sitting directly after the MEM/WB pipeline register and consuming its `wb_*` outputs. It selects and aligns the final result, drives the GPR write port, and owns the architectural HI/LO registers. It also counts retired instructions and, optionally, buffers a commit trace for the debug/trace sink behind a valid/ready handshake.

---
 rtl/wb_stage.sv | 167 ++++++++++++++++
 tb/tb_wb_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: MIPS writeback stage.
// Aligns load data and picks the GPR write result. Holds the HI/LO registers
// and the retired-instruction counter.
// Optional commit-trace FIFO with a valid/ready drain, built only when the
// WB_TRACE_EN macro is defined. Without it, the trace outputs are tied to 0.
module wb_stage #(
    parameter int TRACE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_inst,
    input  logic [31:0] wb_res,
    input  logic [31:0] wb_hi,
    input  logic [31:0] wb_lo,
    input  logic [31:0] wb_rdata,
    input  logic        wb_load,
    input  logic        wb_al,
    input  logic        wb_regwen,
    input  logic [5:0]  wb_wreg,
    input  logic [1:0]  wb_rhilo,
    input  logic [1:0]  wb_whilo,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q,
    output logic [31:0] retired,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_wnum,
    output logic [31:0] trace_wdata,
    output logic        trace_ovf
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;

    // A zero PC is a bubble inserted by the pipeline.
    logic valid;
    assign valid = (wb_pc != 32'd0);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] res_sel;

    // Little-endian lane extraction and sign/zero extension for sub-word loads.
    always_comb begin
        ld_byte = wb_rdata[7:0];
        case (wb_res[1:0])
            2'd1:    ld_byte = wb_rdata[15:8];
            2'd2:    ld_byte = wb_rdata[23:16];
            2'd3:    ld_byte = wb_rdata[31:24];
            default: ld_byte = wb_rdata[7:0];
        endcase
        ld_half = wb_res[1] ? wb_rdata[31:16] : wb_rdata[15:0];
        case (wb_inst[31:26])
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'd0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = wb_rdata;
        endcase
    end

    // Result priority: load, link, MFHI, MFLO, then the ALU result.
    always_comb begin
        res_sel = wb_res;
        if (wb_load)          res_sel = ld_data;
        else if (wb_al)       res_sel = wb_pc + 32'd8;
        else if (wb_rhilo[1]) res_sel = hi_q;
        else if (wb_rhilo[0]) res_sel = lo_q;
    end

    // GPR write port is purely combinational; $0 and non-GPR targets are suppressed.
    assign rf_we    = valid & wb_regwen & ~wb_wreg[5] & (wb_wreg[4:0] != 5'd0);
    assign rf_waddr = wb_wreg[4:0];
    assign rf_wdata = res_sel;

    // HI/LO update on committing instructions; MFHI/MFLO see the old value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (valid) begin
            if (wb_whilo[1]) hi_q <= wb_hi;
            if (wb_whilo[0]) lo_q <= wb_lo;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)    retired <= 32'd0;
        else if (valid) retired <= retired + 32'd1;
    end

`ifdef WB_TRACE_EN
    localparam int AW = $clog2(TRACE_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(TRACE_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_ent_t;

    trace_ent_t    mem [TRACE_DEPTH];
    trace_ent_t    head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          full, do_pop, do_push;

    assign full    = (cnt == CNT_FULL);
    assign do_pop  = trace_valid & trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = rf_we & (~full | do_pop);

    // Storage needs no reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= '{pc: wb_pc, wnum: rf_waddr, wdata: rf_wdata};
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            trace_ovf <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
            if (rf_we & full & ~do_pop) trace_ovf <= 1'b1;
        end
    end

    assign trace_valid = (cnt != '0);
    assign head        = trace_valid ? mem[rd_ptr] : '0;
    assign trace_pc    = head.pc;
    assign trace_wnum  = head.wnum;
    assign trace_wdata = head.wdata;

    logic unused_ok;
    assign unused_ok = ^wb_inst[25:0];
`else
    assign trace_valid = 1'b0;
    assign trace_pc    = 32'd0;
    assign trace_wnum  = 5'd0;
    assign trace_wdata = 32'd0;
    assign trace_ovf   = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{wb_inst[25:0], trace_ready};
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage. Expected GPR writes and trace
// entries are queued as stimulus is driven and compared as the DUT shows them.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] wb_pc, wb_inst, wb_res, wb_hi, wb_lo, wb_rdata;
    logic        wb_load, wb_al, wb_regwen;
    logic [5:0]  wb_wreg;
    logic [1:0]  wb_rhilo, wb_whilo;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, hi_q, lo_q, retired;
    logic        trace_valid, trace_ready, trace_ovf;
    logic [31:0] trace_pc, trace_wdata;
    logic [4:0]  trace_wnum;

    always #5 clk = ~clk;

    wb_stage #(.TRACE_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_res(wb_res),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_rdata(wb_rdata),
        .wb_load(wb_load), .wb_al(wb_al), .wb_regwen(wb_regwen),
        .wb_wreg(wb_wreg), .wb_rhilo(wb_rhilo), .wb_whilo(wb_whilo),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .hi_q(hi_q), .lo_q(lo_q), .retired(retired),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_wnum(trace_wnum),
        .trace_wdata(trace_wdata), .trace_ovf(trace_ovf)
    );

    typedef struct {
        logic [31:0] pc, inst, res, hi, lo, rdata;
        logic        load, al, regwen;
        logic [5:0]  wreg;
        logic [1:0]  rhilo, whilo;
    } wbin_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } rfexp_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trexp_t;

    int     n_chk = 0;
    int     n_bad = 0;
    rfexp_t rfq[$];
    trexp_t tq[$];
    logic [31:0] hi_m, lo_m, ret_m;
    logic        ovf_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic wbin_t nop();
        wbin_t x;
        x.pc = 32'd0; x.inst = 32'd0; x.res = 32'd0; x.hi = 32'd0; x.lo = 32'd0;
        x.rdata = 32'd0; x.load = 1'b0; x.al = 1'b0; x.regwen = 1'b0;
        x.wreg = 6'd0; x.rhilo = 2'b00; x.whilo = 2'b00;
        return x;
    endfunction

    function automatic wbin_t alu(input logic [31:0] pc, input logic [5:0] wreg, input logic [31:0] res);
        wbin_t x = nop();
        x.pc = pc; x.wreg = wreg; x.res = res; x.regwen = 1'b1;
        return x;
    endfunction

    function automatic wbin_t ld(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rdata);
        wbin_t x = alu(32'h0040_0100, 6'd5, addr);
        x.load = 1'b1; x.inst = {op, 26'h0}; x.rdata = rdata;
        return x;
    endfunction

    // Reference result: memory word viewed as four little-endian bytes.
    function automatic logic [31:0] exp_res(input wbin_t x);
        logic [7:0]  b [4];
        logic [7:0]  sb;
        logic [15:0] sh;
        for (int i = 0; i < 4; i++) b[i] = x.rdata[8*i +: 8];
        sb = b[x.res[1:0]];
        sh = {b[{x.res[1], 1'b1}], b[{x.res[1], 1'b0}]};
        if (x.load) begin
            case (x.inst[31:26])
                6'b100000: return {{24{sb[7]}}, sb};
                6'b100100: return {24'h0, sb};
                6'b100001: return {{16{sh[15]}}, sh};
                6'b100101: return {16'h0, sh};
                default:   return x.rdata;
            endcase
        end
        if (x.al)       return x.pc + 32'd8;
        if (x.rhilo[1]) return hi_m;
        if (x.rhilo[0]) return lo_m;
        return x.res;
    endfunction

    function automatic void reset_model();
        hi_m = 32'd0; lo_m = 32'd0; ret_m = 32'd0; ovf_m = 1'b0;
        tq.delete(); rfq.delete();
    endfunction

    task automatic drive(input wbin_t x, input logic rdy);
        wb_pc = x.pc; wb_inst = x.inst; wb_res = x.res; wb_hi = x.hi; wb_lo = x.lo;
        wb_rdata = x.rdata; wb_load = x.load; wb_al = x.al; wb_regwen = x.regwen;
        wb_wreg = x.wreg; wb_rhilo = x.rhilo; wb_whilo = x.whilo; trace_ready = rdy;
    endtask

    // Drive one WB instruction (called at posedge+1), check at negedge, advance the model.
    task automatic step(input string tag, input wbin_t x, input logic rdy);
        rfexp_t e;
        logic   pop, push;
        drive(x, rdy);
        e.we = (x.pc != 0) && x.regwen && !x.wreg[5] && (x.wreg[4:0] != 0);
        e.a  = x.wreg[4:0];
        e.d  = exp_res(x);
        rfq.push_back(e);
        @(negedge clk);
        e = rfq.pop_front();
        chk({tag, ".we"}, {31'd0, rf_we}, {31'd0, e.we});
        chk({tag, ".waddr"}, {27'd0, rf_waddr}, {27'd0, e.a});
        chk({tag, ".wdata"}, rf_wdata, e.d);
        chk({tag, ".hi"}, hi_q, hi_m);
        chk({tag, ".lo"}, lo_q, lo_m);
        chk({tag, ".retired"}, retired, ret_m);
`ifdef WB_TRACE_EN
        chk({tag, ".tvalid"}, {31'd0, trace_valid}, {31'd0, tq.size() != 0});
        chk({tag, ".tovf"}, {31'd0, trace_ovf}, {31'd0, ovf_m});
        if (tq.size() != 0) begin
            chk({tag, ".tpc"}, trace_pc, tq[0].pc);
            chk({tag, ".twnum"}, {27'd0, trace_wnum}, {27'd0, tq[0].wnum});
            chk({tag, ".twdata"}, trace_wdata, tq[0].wdata);
        end
        pop  = (tq.size() != 0) && rdy;
        push = e.we;
        if (pop) void'(tq.pop_front());
        if (push) begin
            if (tq.size() >= 4) ovf_m = 1'b1;
            else tq.push_back('{pc: x.pc, wnum: e.a, wdata: e.d});
        end
`else
        chk({tag, ".tvalid"}, {31'd0, trace_valid}, 32'd0);
        chk({tag, ".tovf"}, {31'd0, trace_ovf}, 32'd0);
        chk({tag, ".tpc"}, trace_pc, 32'd0);
        pop = 1'b0; push = 1'b0;
`endif
        if (x.pc != 0) begin
            if (x.whilo[1]) hi_m = x.hi;
            if (x.whilo[0]) lo_m = x.lo;
            ret_m = ret_m + 32'd1;
        end
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".hi"}, hi_q, 32'd0);
        chk({tag, ".lo"}, lo_q, 32'd0);
        chk({tag, ".retired"}, retired, 32'd0);
        chk({tag, ".rf_we"}, {31'd0, rf_we}, 32'd0);
        chk({tag, ".tvalid"}, {31'd0, trace_valid}, 32'd0);
        chk({tag, ".tovf"}, {31'd0, trace_ovf}, 32'd0);
        chk({tag, ".tpc"}, trace_pc, 32'd0);
        chk({tag, ".twnum"}, {27'd0, trace_wnum}, 32'd0);
        chk({tag, ".twdata"}, trace_wdata, 32'd0);
    endtask

    task automatic do_reset();
        drive(nop(), 1'b0);
        #2 resetn = 1'b0;
        #1 check_all_zero("reset");
        reset_model();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        wbin_t x;
        resetn = 1'b1;
        drive(nop(), 1'b0);
        reset_model();
        @(posedge clk); #1;
        do_reset();

        // Load alignment
        step("lb",   ld(6'b100000, 32'h1003, 32'h80FF_1234), 1'b1);
        step("lbu",  ld(6'b100100, 32'h1003, 32'h80FF_1234), 1'b1);
        step("lh",   ld(6'b100001, 32'h1002, 32'h80FF_1234), 1'b1);
        step("lhu",  ld(6'b100101, 32'h1002, 32'h80FF_1234), 1'b1);
        step("lb0",  ld(6'b100000, 32'h1000, 32'h80FF_1234), 1'b1);
        step("lw",   ld(6'b100011, 32'h1000, 32'h80FF_1234), 1'b1);
        step("ldoth", ld(6'b110000, 32'h1001, 32'hCAFE_F00D), 1'b1);

        // Link and destination gating
        x = alu(32'hBFC0_0010, 6'd31, 32'h0); x.al = 1'b1;
        step("jal", x, 1'b1);
        x.wreg = 6'd0;  step("jal_r0", x, 1'b1);
        x.wreg = 6'h3F; step("jal_ngpr", x, 1'b1);
        x = alu(32'hFFFF_FFFC, 6'd2, 32'h0); x.al = 1'b1; x.rhilo = 2'b10;
        step("jal_wrap", x, 1'b1);

        // HI/LO: MULT, MFHI/MFLO, bubble with whilo
        x = alu(32'h0040_0200, 6'd0, 32'h0); x.regwen = 1'b0;
        x.whilo = 2'b11; x.hi = 32'h1; x.lo = 32'h2;
        step("mult", x, 1'b1);
        x = alu(32'h0040_0204, 6'd8, 32'h77); x.rhilo = 2'b10; step("mfhi", x, 1'b1);
        x = alu(32'h0040_0208, 6'd9, 32'h77); x.rhilo = 2'b01; step("mflo", x, 1'b1);
        x = nop(); x.whilo = 2'b11; x.hi = 32'hAAAA; x.lo = 32'hBBBB; x.regwen = 1'b1; x.wreg = 6'd4;
        step("bubble", x, 1'b1);
        x = alu(32'h0040_020C, 6'd0, 32'h0); x.regwen = 1'b0; x.whilo = 2'b01; x.lo = 32'h55;
        step("mtlo", x, 1'b1);
        x = alu(32'h0040_0210, 6'd10, 32'h0); x.rhilo = 2'b11; step("mfhi2", x, 1'b1);
        for (int i = 0; i < 3; i++) step("idle", nop(), 1'b1);

        // Overflow: 5 writes with sink stalled, then drain
        do_reset();
        for (int i = 0; i < 5; i++)
            step("ovf_fill", alu(32'h0000_1000 + 32'(4*i), 6'(i + 1), 32'h100 + 32'(i)), 1'b0);
        step("ovf_hold", nop(), 1'b0);
        for (int i = 0; i < 6; i++) step("ovf_drain", nop(), 1'b1);

        // Full with push and pop every cycle: no drop
        do_reset();
        for (int i = 0; i < 4; i++)
            step("full_fill", alu(32'h0000_2000 + 32'(4*i), 6'(i + 3), 32'h200 + 32'(i)), 1'b0);
        for (int i = 0; i < 10; i++)
            step("full_pp", alu(32'h0000_3000 + 32'(4*i), 6'(i + 11), 32'h300 + 32'(i)), 1'b1);
        step("drain", nop(), 1'b1);
        step("drain", nop(), 1'b1);

        // Asynchronous reset mid-drain, away from any clock edge
        do_reset();
        step("post_rst", alu(32'h0000_4000, 6'd7, 32'h4444), 1'b1);
        step("post_rst2", nop(), 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
